// File: rtl/nfc_command_dispatch_pkg.sv
// Shared ACG field widths, idle-bus defaults and dispatcher state encoding
// for the NFC command front-end.
package nfc_command_dispatch_pkg;

    localparam int unsigned ACG_CMD_W = 8;
    localparam int unsigned ACG_OPT_W = 3;
    localparam int unsigned ACG_NOD_W = 16;
    localparam int unsigned ACG_CAD_W = 40;

    // TargetWay idles at all-ones, but its width is per-instance, so it lives in the top
    localparam logic [ACG_CMD_W-1:0] IDLE_COMMAND       = '0;
    localparam logic [ACG_OPT_W-1:0] IDLE_COMMANDOPTION = '0;
    localparam logic [ACG_NOD_W-1:0] IDLE_NUMOFDATA     = '0;
    localparam logic                 IDLE_CASELECT      = 1'b1;
    localparam logic [ACG_CAD_W-1:0] IDLE_CADATA        = '0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_BUSY = 3'b010,
        ST_DONE = 3'b100
    } dispatch_state_t;

endpackage

// File: rtl/nfc_acg_onehot_mux.sv
// One-hot AND-OR selector: returns slice i of i_Data when only i_Select[i] is
// set, and all-zeros when i_Select is zero.
module nfc_acg_onehot_mux #(
    parameter int unsigned Width = 8,
    parameter int unsigned N     = 4
) (
    input  logic [N-1:0]       i_Select,
    input  logic [Width*N-1:0] i_Data,
    output logic [Width-1:0]   o_Data
);

    always_comb begin
        o_Data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            o_Data = o_Data | (i_Data[i*Width +: Width] & {Width{i_Select[i]}});
        end
    end

endmodule

// File: rtl/nfc_command_dispatch.sv
// Host command front-end: gates the command valid out to the sequencers, grants
// the claiming sequencer the shared ACG bus until its last step, flags errors.
module nfc_command_dispatch
    import nfc_command_dispatch_pkg::*;
#(
    parameter int unsigned             NumberOfWays  = 4,
    parameter int unsigned             NumberOfCmds  = 4,
    parameter int unsigned             TimeoutWidth  = 24,
    parameter logic [TimeoutWidth-1:0] TimeoutCycles = 24'hFF_FFFF
) (
    input  logic                                 iSystemClock,
    input  logic                                 iReset,
    input  logic [5:0]                           iOpcode,
    input  logic                                 iCMDValid,
    output logic                                 oCMDReady,
    output logic                                 oCmdValid,
    input  logic [NumberOfCmds-1:0]              iCmdStart,
    input  logic [NumberOfCmds-1:0]              iCmdLastStep,
    input  logic [ACG_CMD_W*NumberOfCmds-1:0]    iCmdACG_Command,
    input  logic [ACG_OPT_W*NumberOfCmds-1:0]    iCmdACG_CommandOption,
    input  logic [NumberOfWays*NumberOfCmds-1:0] iCmdACG_TargetWay,
    input  logic [ACG_NOD_W*NumberOfCmds-1:0]    iCmdACG_NumOfData,
    input  logic [NumberOfCmds-1:0]              iCmdACG_CASelect,
    input  logic [ACG_CAD_W*NumberOfCmds-1:0]    iCmdACG_CAData,
    output logic [ACG_CMD_W-1:0]                 oACG_Command,
    output logic [ACG_OPT_W-1:0]                 oACG_CommandOption,
    output logic [NumberOfWays-1:0]              oACG_TargetWay,
    output logic [ACG_NOD_W-1:0]                 oACG_NumOfData,
    output logic                                 oACG_CASelect,
    output logic [ACG_CAD_W-1:0]                 oACG_CAData,
    output logic [NumberOfCmds-1:0]              oActiveCmd,
    output logic                                 oLastStep,
    output logic                                 oIllegalOpcode,
    output logic                                 oStartConflict,
    output logic                                 oTimeout
);

    localparam logic [NumberOfCmds-1:0] CMD_ONE       = {{(NumberOfCmds-1){1'b0}}, 1'b1};
    localparam logic [TimeoutWidth-1:0] COUNT_ONE     = {{(TimeoutWidth-1){1'b0}}, 1'b1};
    localparam logic [TimeoutWidth-1:0] COUNT_AT_FIRE = TimeoutCycles - COUNT_ONE;

    dispatch_state_t           r_State, w_NextState;
    logic [NumberOfCmds-1:0]   r_Grant;
    logic [TimeoutWidth-1:0]   r_BusyCount;
    logic                      r_IllegalOpcode, r_StartConflict;
    logic [NumberOfCmds-1:0]   w_StartLowest;
    logic                      w_Handshake, w_Accept, w_Complete, w_GrantIdle;
    logic                      w_unused_opcode;

    logic [ACG_CMD_W-1:0]      w_Command;
    logic [ACG_OPT_W-1:0]      w_CommandOption;
    logic [NumberOfWays-1:0]   w_TargetWay;
    logic [ACG_NOD_W-1:0]      w_NumOfData;
    logic                      w_CASelect;
    logic [ACG_CAD_W-1:0]      w_CAData;

    // Opcode decode belongs to the sequencers; it is only carried past here
    assign w_unused_opcode = ^iOpcode;

    assign w_Handshake   = (r_State == ST_IDLE) && iCMDValid;
    assign w_Accept      = w_Handshake && (|iCmdStart);
    assign w_StartLowest = iCmdStart & (~iCmdStart + CMD_ONE);
    assign w_Complete    = (r_State == ST_BUSY) && (|(iCmdLastStep & r_Grant));
    assign w_GrantIdle   = ~(|r_Grant);

    always_comb begin
        w_NextState = r_State;
        oCMDReady   = 1'b0;
        oCmdValid   = 1'b0;
        unique case (r_State)
            ST_IDLE: begin
                oCMDReady = 1'b1;
                oCmdValid = iCMDValid;
                if (w_Accept) w_NextState = ST_BUSY;
            end
            ST_BUSY: if (w_Complete) w_NextState = ST_DONE;
            ST_DONE: w_NextState = ST_IDLE;
            default: w_NextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            r_State         <= ST_IDLE;
            r_Grant         <= '0;
            r_BusyCount     <= '0;
            r_IllegalOpcode <= 1'b0;
            r_StartConflict <= 1'b0;
        end else begin
            r_State         <= w_NextState;
            r_IllegalOpcode <= w_Handshake && !(|iCmdStart);
            r_StartConflict <= w_Accept && (|(iCmdStart & ~w_StartLowest));
            if (w_Accept) begin
                r_Grant     <= w_StartLowest;
                r_BusyCount <= '0;
            end else if (w_Complete) begin
                r_Grant     <= '0;
            end else if ((r_State == ST_BUSY) && (r_BusyCount != TimeoutCycles)) begin
                r_BusyCount <= r_BusyCount + COUNT_ONE;
            end
        end
    end

    // Counter parks at TimeoutCycles, so the compare below matches only once per command
    assign oTimeout       = (r_State == ST_BUSY) && (r_BusyCount == COUNT_AT_FIRE);
    assign oLastStep      = (r_State == ST_DONE);
    assign oIllegalOpcode = r_IllegalOpcode;
    assign oStartConflict = r_StartConflict;
    assign oActiveCmd     = r_Grant;

    nfc_acg_onehot_mux #(.Width(ACG_CMD_W), .N(NumberOfCmds)) u_mux_command (
        .i_Select(r_Grant), .i_Data(iCmdACG_Command), .o_Data(w_Command));
    nfc_acg_onehot_mux #(.Width(ACG_OPT_W), .N(NumberOfCmds)) u_mux_option (
        .i_Select(r_Grant), .i_Data(iCmdACG_CommandOption), .o_Data(w_CommandOption));
    nfc_acg_onehot_mux #(.Width(NumberOfWays), .N(NumberOfCmds)) u_mux_way (
        .i_Select(r_Grant), .i_Data(iCmdACG_TargetWay), .o_Data(w_TargetWay));
    nfc_acg_onehot_mux #(.Width(ACG_NOD_W), .N(NumberOfCmds)) u_mux_numofdata (
        .i_Select(r_Grant), .i_Data(iCmdACG_NumOfData), .o_Data(w_NumOfData));
    nfc_acg_onehot_mux #(.Width(1), .N(NumberOfCmds)) u_mux_caselect (
        .i_Select(r_Grant), .i_Data(iCmdACG_CASelect), .o_Data(w_CASelect));
    nfc_acg_onehot_mux #(.Width(ACG_CAD_W), .N(NumberOfCmds)) u_mux_cadata (
        .i_Select(r_Grant), .i_Data(iCmdACG_CAData), .o_Data(w_CAData));

    assign oACG_Command       = w_GrantIdle ? IDLE_COMMAND       : w_Command;
    assign oACG_CommandOption = w_GrantIdle ? IDLE_COMMANDOPTION : w_CommandOption;
    assign oACG_TargetWay     = w_GrantIdle ? '1                 : w_TargetWay;
    assign oACG_NumOfData     = w_GrantIdle ? IDLE_NUMOFDATA     : w_NumOfData;
    assign oACG_CASelect      = w_GrantIdle ? IDLE_CASELECT      : w_CASelect;
    assign oACG_CAData        = w_GrantIdle ? IDLE_CADATA        : w_CAData;

endmodule
